// File: rtl/control_pipe_pkg.sv
// Shared types for the pipelined control decoder: opcodes, function codes,
// the per-stage control word and the halt/exception enumerations.
package control_pipe_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ARITHM = 4'h0;
  localparam opcode_t OP_LW     = 4'h1;
  localparam opcode_t OP_SW     = 4'h2;
  localparam opcode_t OP_BLT    = 4'h3;
  localparam opcode_t OP_BGT    = 4'h4;
  localparam opcode_t OP_BE     = 4'h5;
  localparam opcode_t OP_JMP    = 4'h6;
  localparam opcode_t OP_HALT   = 4'h7;

  typedef enum logic [3:0] {
    F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOT, F_ROR, F_ROL, F_SHL, F_SHR
  } control_e;

  typedef enum logic [1:0] {SEL_NONE, FOURBIT, EIGHTBIT, TWELVEBIT} sel_t;

  typedef struct packed {
    logic alu_op;
    sel_t offset_sel;
    logic mem2r;
    logic memwr;
    logic reg_wr;
    logic r0_read;
    logic se_imm_a;
    logic is_branch;
    logic is_halt;
  } ctrl_word_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_e;

  typedef enum logic [2:0] {EXC_NONE, HALT_INSN, ILLEGAL, DIV0, OVF} exc_cause_e;

  localparam ctrl_word_t CTRL_NOP = '0;

  // Rotates and shifts carry a 4-bit immediate shift amount.
  function automatic logic is_shift(control_e f);
    return (f == F_ROR) || (f == F_ROL) || (f == F_SHL) || (f == F_SHR);
  endfunction

endpackage

// File: rtl/control_pipe_if.sv
// ID-side request, EX-side status and per-stage control outputs of control_pipe.
interface control_pipe_if #(
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
);
  import control_pipe_pkg::*;

  logic                    valid_in;
  opcode_t                 opcode;
  control_e                func;
  logic                    stall;
  logic                    flush;
  logic                    div0;
  logic                    overflow;
  logic                    resume;
  logic                    accept;
  ctrl_word_t [STAGES-1:0] ctrl_o;
  logic [STAGES-1:0]       vld_o;
  logic                    halt_sys;
  exc_cause_e              exc_cause;
  logic                    ovf_sticky;
  logic [CNT_W-1:0]        retired;

  modport master (
    output valid_in, opcode, func, stall, flush, div0, overflow, resume,
    input  accept, ctrl_o, vld_o, halt_sys, exc_cause, ovf_sticky, retired
  );

  modport slave (
    input  valid_in, opcode, func, stall, flush, div0, overflow, resume,
    output accept, ctrl_o, vld_o, halt_sys, exc_cause, ovf_sticky, retired
  );

endinterface

// File: rtl/control_pipe_decode.sv
// Combinational main-control decode: opcode/func to control word, plus an
// illegal-opcode flag. Illegal opcodes produce the all-zero word.
module ctrl_decode
  import control_pipe_pkg::*;
(
  input  opcode_t    opcode,
  input  control_e   func,
  output ctrl_word_t word,
  output logic       illegal
);

  always_comb begin
    word    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_ARITHM: begin
        word.reg_wr     = 1'b1;
        word.offset_sel = is_shift(func) ? FOURBIT : SEL_NONE;
      end
      OP_LW: begin
        word.alu_op     = 1'b1;
        word.offset_sel = EIGHTBIT;
        word.mem2r      = 1'b1;
        word.reg_wr     = 1'b1;
      end
      OP_SW: begin
        word.alu_op     = 1'b1;
        word.offset_sel = EIGHTBIT;
        word.memwr      = 1'b1;
      end
      OP_BLT, OP_BGT, OP_BE: begin
        word.offset_sel = EIGHTBIT;
        word.r0_read    = 1'b1;
        word.se_imm_a   = 1'b1;
        word.is_branch  = 1'b1;
      end
      OP_JMP: begin
        word.offset_sel = TWELVEBIT;
        word.se_imm_a   = 1'b1;
        word.is_branch  = 1'b1;
      end
      OP_HALT: begin
        word.is_halt    = 1'b1;
        word.se_imm_a   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined main control: decodes at ID, carries the control word through
// STAGES registered stages, and sequences halts/exceptions with a retire counter.
//
//   state  | meaning
//   RUN    | accepting instructions from ID
//   DRAIN  | halt pending; no new instructions, older stages shift out
//   HALTED | pipeline empty, halt_sys high until resume
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int CNT_W    = 16,
  parameter bit OVF_HALT = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  control_pipe_if.slave bus
);

  ctrl_word_t              dec_word;
  logic                    dec_illegal;

  halt_state_e             state_q, state_d;
  exc_cause_e              cause_q, cause_d;
  logic                    sticky_q, sticky_d;
  ctrl_word_t [STAGES-1:0] word_q, word_d;
  logic [STAGES-1:0]       vld_q, vld_d;
  logic [CNT_W-1:0]        retired_q;

  logic                    trap;
  logic                    accept;
  logic                    halt_sys;

  ctrl_decode u_decode (
    .opcode  (bus.opcode),
    .func    (bus.func),
    .word    (dec_word),
    .illegal (dec_illegal)
  );

  // Only stage 0 (EX) reports exceptions, and only while running.
  assign trap = (state_q == RUN) && vld_q[0] &&
                (bus.div0 || (bus.overflow && OVF_HALT));

  always_comb begin
    word_d = word_q;
    vld_d  = vld_q;
    for (int k = 1; k < STAGES; k++) begin
      word_d[k] = word_q[k-1];
      vld_d[k]  = vld_q[k-1];
    end
    // The excepting instruction is squashed before it can reach a writing stage.
    if (trap) begin
      word_d[1] = CTRL_NOP;
      vld_d[1]  = 1'b0;
    end
    if (accept && !dec_illegal) begin
      word_d[0] = dec_word;
      vld_d[0]  = 1'b1;
    end else begin
      word_d[0] = CTRL_NOP;
      vld_d[0]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cause_q  <= EXC_NONE;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    sticky_d = sticky_q;
    case (state_q)
      RUN: begin
        if (vld_q[0] && bus.overflow && !OVF_HALT) sticky_d = 1'b1;
        // A halt with nothing left in flight skips straight to HALTED.
        if (trap) begin
          cause_d = bus.div0 ? DIV0 : OVF;
          state_d = (|vld_d) ? DRAIN : HALTED;
        end else if (accept && (dec_illegal || dec_word.is_halt)) begin
          cause_d = dec_illegal ? ILLEGAL : HALT_INSN;
          state_d = (|vld_d) ? DRAIN : HALTED;
        end
      end
      DRAIN: begin
        if (!(|vld_d)) state_d = HALTED;
      end
      HALTED: begin
        if (bus.resume) begin
          state_d  = RUN;
          cause_d  = EXC_NONE;
          sticky_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    accept   = bus.valid_in && (state_q == RUN) && !bus.stall && !bus.flush && !trap;
    halt_sys = (state_q == HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q    <= '0;
      vld_q     <= '0;
      retired_q <= '0;
    end else begin
      word_q <= word_d;
      vld_q  <= vld_d;
      if (vld_q[STAGES-1]) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.accept     = accept;
  assign bus.ctrl_o     = word_q;
  assign bus.vld_o      = vld_q;
  assign bus.halt_sys   = halt_sys;
  assign bus.exc_cause  = cause_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: a behavioural model tracks DUT A
// (3 stages, overflow traps); DUT B (2 stages, 4-bit counter, no overflow trap) runs directed cases.
module tb_control_pipe;
  import control_pipe_pkg::*;

  localparam int S   = 3;
  localparam int CW  = 16;
  localparam int SB  = 2;
  localparam int CWB = 4;
  localparam int MR  = 0;
  localparam int MD  = 1;
  localparam int MH  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_nb;
  int   checks = 0;
  int   errors = 0;

  control_pipe_if #(.STAGES(S),  .CNT_W(CW))  bus_a ();
  control_pipe_if #(.STAGES(SB), .CNT_W(CWB)) bus_b ();

  control_pipe #(.STAGES(S), .CNT_W(CW), .OVF_HALT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  control_pipe #(.STAGES(SB), .CNT_W(CWB), .OVF_HALT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_nb), .bus(bus_b)
  );

  // model of DUT A
  ctrl_word_t      m_w [S];
  bit              m_v [S];
  int              m_state;
  exc_cause_e      m_cause;
  logic [CW-1:0]   m_ret;

  function automatic ctrl_word_t ref_dec(input logic [3:0] op, input control_e f);
    ctrl_word_t w;
    bit mem, br;
    w   = CTRL_NOP;
    mem = (op == OP_LW) || (op == OP_SW);
    br  = (op == OP_BLT) || (op == OP_BGT) || (op == OP_BE);
    w.alu_op    = mem;
    w.mem2r     = (op == OP_LW);
    w.memwr     = (op == OP_SW);
    w.reg_wr    = (op == OP_LW) || (op == OP_ARITHM);
    w.r0_read   = br;
    w.is_branch = br || (op == OP_JMP);
    w.se_imm_a  = br || (op == OP_JMP) || (op == OP_HALT);
    w.is_halt   = (op == OP_HALT);
    if (mem || br) w.offset_sel = EIGHTBIT;
    else if (op == OP_JMP) w.offset_sel = TWELVEBIT;
    else if (op == OP_ARITHM && f inside {F_ROR, F_ROL, F_SHL, F_SHR}) w.offset_sel = FOURBIT;
    else w.offset_sel = SEL_NONE;
    return w;
  endfunction

  function automatic bit ref_illegal(input logic [3:0] op);
    return op > 4'd7;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S; k++) begin
      m_w[k] = CTRL_NOP;
      m_v[k] = 1'b0;
    end
    m_state = MR;
    m_cause = EXC_NONE;
    m_ret   = '0;
  endtask

  task automatic idle_a();
    bus_a.valid_in = 1'b0; bus_a.opcode = OP_ARITHM; bus_a.func = F_ADD;
    bus_a.stall = 1'b0; bus_a.flush = 1'b0; bus_a.div0 = 1'b0;
    bus_a.overflow = 1'b0; bus_a.resume = 1'b0; rst_n = 1'b1;
  endtask

  task automatic idle_b();
    bus_b.valid_in = 1'b0; bus_b.opcode = OP_ARITHM; bus_b.func = F_ADD;
    bus_b.stall = 1'b0; bus_b.flush = 1'b0; bus_b.div0 = 1'b0;
    bus_b.overflow = 1'b0; bus_b.resume = 1'b0; rst_nb = 1'b1;
  endtask

  // One clock of DUT A with whatever inputs are currently driven.
  task automatic step_a();
    bit acc, trap, ill, any;
    ctrl_word_t dw;
    ctrl_word_t nw [S];
    bit nv [S];
    @(negedge clk);
    trap = (m_state == MR) && m_v[0] && (bus_a.div0 || bus_a.overflow);
    acc  = bus_a.valid_in && (m_state == MR) && !bus_a.stall && !bus_a.flush && !trap;
    checks++;
    if (bus_a.accept !== acc) begin
      errors++;
      $display("FAIL accept t=%0t got %b want %b", $time, bus_a.accept, acc);
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      dw  = ref_dec(bus_a.opcode, bus_a.func);
      ill = ref_illegal(bus_a.opcode);
      if (m_v[S-1]) m_ret++;
      for (int k = S-1; k > 0; k--) begin
        nw[k] = m_w[k-1];
        nv[k] = m_v[k-1];
      end
      if (trap) begin
        nw[1] = CTRL_NOP;
        nv[1] = 1'b0;
      end
      nv[0] = acc && !ill;
      nw[0] = nv[0] ? dw : CTRL_NOP;
      any = 1'b0;
      for (int k = 0; k < S; k++) any |= nv[k];
      if (m_state == MR) begin
        if (trap) begin
          m_cause = bus_a.div0 ? DIV0 : OVF;
          m_state = any ? MD : MH;
        end else if (acc && (ill || bus_a.opcode == OP_HALT)) begin
          m_cause = ill ? ILLEGAL : HALT_INSN;
          m_state = any ? MD : MH;
        end
      end else if (m_state == MD) begin
        if (!any) m_state = MH;
      end else if (bus_a.resume) begin
        m_state = MR;
        m_cause = EXC_NONE;
      end
      m_w = nw;
      m_v = nv;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < S; k++) begin
      checks++;
      if (bus_a.vld_o[k] !== m_v[k]) begin
        errors++;
        $display("FAIL vld_o[%0d] t=%0t got %b want %b", k, $time, bus_a.vld_o[k], m_v[k]);
      end
      checks++;
      if (bus_a.ctrl_o[k] !== m_w[k]) begin
        errors++;
        $display("FAIL ctrl_o[%0d] t=%0t got %h want %h", k, $time, bus_a.ctrl_o[k], m_w[k]);
      end
    end
    checks++;
    if (bus_a.halt_sys !== (m_state == MH)) begin
      errors++;
      $display("FAIL halt_sys t=%0t got %b want %b", $time, bus_a.halt_sys, m_state == MH);
    end
    checks++;
    if (bus_a.exc_cause !== m_cause) begin
      errors++;
      $display("FAIL exc_cause t=%0t got %0d want %0d", $time, bus_a.exc_cause, m_cause);
    end
    checks++;
    if (bus_a.ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky_a t=%0t got %b want 0", $time, bus_a.ovf_sticky);
    end
    checks++;
    if (bus_a.retired !== m_ret) begin
      errors++;
      $display("FAIL retired t=%0t got %0d want %0d", $time, bus_a.retired, m_ret);
    end
  endtask

  task automatic issue_a(input logic [3:0] op, input control_e f);
    bus_a.valid_in = 1'b1;
    bus_a.opcode   = op;
    bus_a.func     = f;
    step_a();
    idle_a();
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_a();
    rst_n = 1'b0;
    step_a();
    step_a();
    rst_n = 1'b1;
    checks++;
    if (bus_a.retired !== 16'd0 || bus_a.vld_o !== 3'b000 || bus_a.halt_sys !== 1'b0 ||
        bus_a.exc_cause !== EXC_NONE) begin
      errors++;
      $display("FAIL reset_state got ret=%0d vld=%b halt=%b cause=%0d want 0 000 0 0",
               bus_a.retired, bus_a.vld_o, bus_a.halt_sys, bus_a.exc_cause);
    end
  endtask

  task automatic test_decode_seq();
    logic [3:0] ops  [4] = '{OP_LW, OP_SW, OP_ARITHM, OP_BE};
    sel_t       sels [4] = '{EIGHTBIT, EIGHTBIT, FOURBIT, EIGHTBIT};
    logic [3:0] flg  [4] = '{4'b1010, 4'b0100, 4'b0010, 4'b0001}; // mem2r memwr reg_wr r0_read
    ctrl_word_t w;
    for (int i = 0; i < 4; i++) begin
      issue_a(ops[i], F_ROL);
      w = bus_a.ctrl_o[0];
      checks++;
      if (w.offset_sel !== sels[i] || {w.mem2r, w.memwr, w.reg_wr, w.r0_read} !== flg[i]) begin
        errors++;
        $display("FAIL decode_seq[%0d] got sel=%0d flags=%b want sel=%0d flags=%b",
                 i, w.offset_sel, {w.mem2r, w.memwr, w.reg_wr, w.r0_read}, sels[i], flg[i]);
      end
    end
    for (int i = 0; i < 3; i++) step_a();
    checks++;
    if (bus_a.retired !== 16'd4) begin
      errors++;
      $display("FAIL retired_after_seq got %0d want 4", bus_a.retired);
    end
  endtask

  task automatic test_stall();
    bus_a.valid_in = 1'b1; bus_a.opcode = OP_ARITHM; bus_a.func = F_ADD;
    bus_a.stall = 1'b1;
    step_a();
    checks++;
    if (bus_a.vld_o[0] !== 1'b0) begin
      errors++; $display("FAIL stall_bubble got %b want 0", bus_a.vld_o[0]);
    end
    bus_a.stall = 1'b0;
    step_a();
    checks++;
    if (bus_a.vld_o[0] !== 1'b1) begin
      errors++; $display("FAIL stall_release got %b want 1", bus_a.vld_o[0]);
    end
    bus_a.stall = 1'b1; bus_a.flush = 1'b1;
    step_a();
    checks++;
    if (bus_a.vld_o[0] !== 1'b0) begin
      errors++; $display("FAIL stall_flush got %b want 0", bus_a.vld_o[0]);
    end
    bus_a.stall = 1'b0;
    step_a();
    idle_a();
    for (int i = 0; i < 3; i++) step_a();
  endtask

  task automatic test_halt();
    logic [CW-1:0] base;
    base = m_ret;
    issue_a(OP_LW, F_ADD);
    issue_a(OP_SW, F_ADD);
    issue_a(OP_HALT, F_ADD);
    step_a();
    step_a();
    checks++;
    if (bus_a.halt_sys !== 1'b0) begin
      errors++; $display("FAIL halt_early got %b want 0", bus_a.halt_sys);
    end
    step_a();
    checks++;
    if (bus_a.halt_sys !== 1'b1 || bus_a.exc_cause !== HALT_INSN || bus_a.retired !== base + 16'd3) begin
      errors++;
      $display("FAIL halt_insn got halt=%b cause=%0d ret=%0d want 1 %0d %0d",
               bus_a.halt_sys, bus_a.exc_cause, bus_a.retired, HALT_INSN, base + 16'd3);
    end
    bus_a.valid_in = 1'b1;
    step_a();
    step_a();
    bus_a.resume = 1'b1;
    step_a();
    idle_a();
    checks++;
    if (bus_a.halt_sys !== 1'b0 || bus_a.exc_cause !== EXC_NONE) begin
      errors++;
      $display("FAIL resume got halt=%b cause=%0d want 0 0", bus_a.halt_sys, bus_a.exc_cause);
    end
  endtask

  task automatic test_div0();
    logic [CW-1:0] base;
    base = m_ret;
    issue_a(OP_LW, F_ADD);
    issue_a(OP_ARITHM, F_ADD);
    bus_a.div0 = 1'b1;
    step_a();
    idle_a();
    checks++;
    if (bus_a.vld_o[1] !== 1'b0 || bus_a.vld_o[2] !== 1'b1 || bus_a.exc_cause !== DIV0) begin
      errors++;
      $display("FAIL div0_squash got vld=%b cause=%0d want 100 %0d",
               bus_a.vld_o, bus_a.exc_cause, DIV0);
    end
    step_a();
    checks++;
    if (bus_a.halt_sys !== 1'b1 || bus_a.retired !== base + 16'd1) begin
      errors++;
      $display("FAIL div0_halt got halt=%b ret=%0d want 1 %0d",
               bus_a.halt_sys, bus_a.retired, base + 16'd1);
    end
    bus_a.resume = 1'b1;
    step_a();
    idle_a();
  endtask

  task automatic test_ovf_trap();
    issue_a(OP_ARITHM, F_SUB);
    bus_a.overflow = 1'b1;
    step_a();
    idle_a();
    checks++;
    if (bus_a.halt_sys !== 1'b1 || bus_a.exc_cause !== OVF || bus_a.vld_o !== 3'b000) begin
      errors++;
      $display("FAIL ovf_trap got halt=%b cause=%0d vld=%b want 1 %0d 000",
               bus_a.halt_sys, bus_a.exc_cause, bus_a.vld_o, OVF);
    end
    bus_a.resume = 1'b1;
    step_a();
    idle_a();
  endtask

  task automatic test_illegal_reset();
    issue_a(OP_LW, F_ADD);
    issue_a(4'hF, F_ADD);
    checks++;
    if (bus_a.exc_cause !== ILLEGAL || bus_a.vld_o[0] !== 1'b0 || bus_a.halt_sys !== 1'b0) begin
      errors++;
      $display("FAIL illegal got cause=%0d vld0=%b halt=%b want %0d 0 0",
               bus_a.exc_cause, bus_a.vld_o[0], bus_a.halt_sys, ILLEGAL);
    end
    rst_n = 1'b0;
    step_a();
    rst_n = 1'b1;
    checks++;
    if (bus_a.exc_cause !== EXC_NONE || bus_a.vld_o !== 3'b000 || bus_a.retired !== 16'd0 ||
        bus_a.halt_sys !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_drain got cause=%0d vld=%b ret=%0d halt=%b want 0 000 0 0",
               bus_a.exc_cause, bus_a.vld_o, bus_a.retired, bus_a.halt_sys);
    end
    step_a();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      bus_a.valid_in = ($urandom_range(0, 9) < 7);
      if (r < 85)      bus_a.opcode = 4'($urandom_range(0, 6));
      else if (r < 90) bus_a.opcode = OP_HALT;
      else             bus_a.opcode = 4'($urandom_range(8, 15));
      bus_a.func     = control_e'(4'($urandom_range(0, 9)));
      bus_a.stall    = ($urandom_range(0, 99) < 15);
      bus_a.flush    = ($urandom_range(0, 99) < 10);
      bus_a.div0     = ($urandom_range(0, 99) < 4);
      bus_a.overflow = ($urandom_range(0, 99) < 4);
      bus_a.resume   = ($urandom_range(0, 99) < 30);
      rst_n          = ($urandom_range(0, 199) != 0);
      step_a();
    end
    idle_a();
  endtask

  task automatic test_ovf_sticky_b();
    idle_b();
    rst_nb = 1'b0;
    tick_b();
    rst_nb = 1'b1;
    bus_b.valid_in = 1'b1; bus_b.opcode = OP_ARITHM;
    tick_b();
    idle_b();
    bus_b.overflow = 1'b1;
    tick_b();
    idle_b();
    checks++;
    if (bus_b.halt_sys !== 1'b0 || bus_b.ovf_sticky !== 1'b1 || bus_b.vld_o !== 2'b10 ||
        bus_b.exc_cause !== EXC_NONE) begin
      errors++;
      $display("FAIL ovf_nohalt got halt=%b sticky=%b vld=%b cause=%0d want 0 1 10 0",
               bus_b.halt_sys, bus_b.ovf_sticky, bus_b.vld_o, bus_b.exc_cause);
    end
    tick_b();
    checks++;
    if (bus_b.retired !== 4'd1) begin
      errors++; $display("FAIL ovf_retire got %0d want 1", bus_b.retired);
    end
  endtask

  task automatic test_wrap_b();
    bus_b.valid_in = 1'b1; bus_b.opcode = OP_SW;
    for (int i = 0; i < 14; i++) tick_b();
    idle_b();
    for (int i = 0; i < 3; i++) tick_b();
    checks++;
    if (bus_b.retired !== 4'hF) begin
      errors++; $display("FAIL wrap_pre got %0d want 15", bus_b.retired);
    end
    bus_b.valid_in = 1'b1; bus_b.opcode = OP_JMP;
    tick_b();
    idle_b();
    for (int i = 0; i < 3; i++) tick_b();
    checks++;
    if (bus_b.retired !== 4'h0) begin
      errors++; $display("FAIL wrap_post got %0d want 0", bus_b.retired);
    end
  endtask

  task automatic test_resume_b();
    int n;
    bus_b.valid_in = 1'b1; bus_b.opcode = OP_HALT;
    tick_b();
    idle_b();
    n = 0;
    while (bus_b.halt_sys !== 1'b1 && n < 10) begin
      tick_b();
      n++;
    end
    checks++;
    if (bus_b.halt_sys !== 1'b1 || bus_b.exc_cause !== HALT_INSN || bus_b.ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL halt_b got halt=%b cause=%0d sticky=%b want 1 %0d 1",
               bus_b.halt_sys, bus_b.exc_cause, bus_b.ovf_sticky, HALT_INSN);
    end
    bus_b.resume = 1'b1;
    tick_b();
    idle_b();
    checks++;
    if (bus_b.halt_sys !== 1'b0 || bus_b.exc_cause !== EXC_NONE || bus_b.ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL resume_b got halt=%b cause=%0d sticky=%b want 0 0 0",
               bus_b.halt_sys, bus_b.exc_cause, bus_b.ovf_sticky);
    end
  endtask

  initial begin
    model_reset();
    idle_a();
    idle_b();
    rst_n  = 1'b0;
    rst_nb = 1'b0;
    test_reset();
    test_decode_seq();
    test_stall();
    test_halt();
    test_div0();
    test_ovf_trap();
    test_illegal_reset();
    test_random();
    test_ovf_sticky_b();
    test_wrap_b();
    test_resume_b();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
